// File: rtl/capture_fifo_sync.sv
// Single-clock capture FIFO with status flags, sticky error flags and overflow counter; CAPTURE_FIFO_WATERMARK_EN adds the O_max_count peak tracker.
// Read data latency 1; writes are dropped and counted when full, reads while empty only set the underflow flag.
module capture_fifo_sync #(
    parameter int pDATA_WIDTH    = 18,
    parameter int pDEPTH         = 2048,
    parameter int pERR_CNT_WIDTH = 8,
    localparam int AW            = $clog2(pDEPTH)
) (
    input  logic                      fe_clk,
    input  logic                      reset_n,
    input  logic                      I_wr,
    input  logic [pDATA_WIDTH-1:0]    I_data,
    input  logic                      I_rd,
    input  logic                      I_flush,
    input  logic                      I_clear_errors,
    input  logic [AW:0]               I_full_thresh,
    input  logic [AW:0]               I_empty_thresh,
    output logic [pDATA_WIDTH-1:0]    O_data,
    output logic                      O_data_valid,
    output logic [AW:0]               O_count,
    output logic [AW:0]               O_max_count,
    output logic                      O_full,
    output logic                      O_empty,
    output logic                      O_full_threshold,
    output logic                      O_empty_threshold,
    output logic                      O_overflow_sticky,
    output logic                      O_underflow_sticky,
    output logic [pERR_CNT_WIDTH-1:0] O_overflow_count,
    output logic                      O_error_flag,
    output logic [5:0]                O_fifo_status
);

    localparam logic [AW:0]               DEPTH_C = (AW+1)'(pDEPTH);
    localparam logic [AW:0]               CNT_ONE = 1;
    localparam logic [AW-1:0]             PTR_ONE = 1;
    localparam logic [pERR_CNT_WIDTH-1:0] ERR_ONE = 1;

    typedef struct packed {
        logic full_thr;
        logic ovf;
        logic full;
        logic empty_thr;
        logic unf;
        logic empty;
    } status_t;

    logic [pDATA_WIDTH-1:0]    r_mem [pDEPTH];
    logic [AW-1:0]             r_wr_ptr;
    logic [AW-1:0]             r_rd_ptr;
    logic [AW:0]               r_count;
    logic [pDATA_WIDTH-1:0]    r_data;
    logic                      r_data_vld;
    logic                      r_full;
    logic                      r_empty;
    logic                      r_full_thr;
    logic                      r_empty_thr;
    logic                      r_ovf_sticky;
    logic                      r_unf_sticky;
    logic [pERR_CNT_WIDTH-1:0] r_ovf_cnt;

    logic        w_wr_ok;
    logic        w_rd_ok;
    logic        w_ovf_evt;
    logic        w_unf_evt;
    logic [AW:0] w_count_nxt;
    status_t     w_status;

    // Flush masks every request in its cycle, so it can never raise an error.
    assign w_wr_ok   = I_wr & ~r_full  & ~I_flush;
    assign w_ovf_evt = I_wr &  r_full  & ~I_flush;
    assign w_rd_ok   = I_rd & ~r_empty & ~I_flush;
    assign w_unf_evt = I_rd &  r_empty & ~I_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (I_flush) begin
            w_count_nxt = '0;
        end else begin
            case ({w_wr_ok, w_rd_ok})
                2'b10:   w_count_nxt = r_count + CNT_ONE;
                2'b01:   w_count_nxt = r_count - CNT_ONE;
                default: w_count_nxt = r_count;
            endcase
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge fe_clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr] <= I_data;
        end
    end

    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data      <= '0;
            r_data_vld  <= 1'b0;
            r_full      <= 1'b0;
            r_empty     <= 1'b1;
            r_full_thr  <= 1'b0;
            r_empty_thr <= 1'b0;
        end else begin
            if (I_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_rd_ok) r_data <= r_mem[r_rd_ptr];
            r_data_vld  <= w_rd_ok;
            r_count     <= w_count_nxt;
            // Flags are computed from the next count so they line up with O_count.
            r_full      <= (w_count_nxt == DEPTH_C);
            r_empty     <= (w_count_nxt == '0);
            r_full_thr  <= (w_count_nxt >= I_full_thresh);
            r_empty_thr <= (w_count_nxt <= I_empty_thresh) && (w_count_nxt != '0);
        end
    end

    // A new error event wins over a coincident clear.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf_sticky <= 1'b0;
            r_unf_sticky <= 1'b0;
            r_ovf_cnt    <= '0;
        end else begin
            if (w_ovf_evt)           r_ovf_sticky <= 1'b1;
            else if (I_clear_errors) r_ovf_sticky <= 1'b0;

            if (w_unf_evt)           r_unf_sticky <= 1'b1;
            else if (I_clear_errors) r_unf_sticky <= 1'b0;

            if (w_ovf_evt) begin
                if (I_clear_errors)         r_ovf_cnt <= ERR_ONE;
                else if (r_ovf_cnt != '1)   r_ovf_cnt <= r_ovf_cnt + ERR_ONE;
            end else if (I_clear_errors) begin
                r_ovf_cnt <= '0;
            end
        end
    end

`ifdef CAPTURE_FIFO_WATERMARK_EN
    logic [AW:0] r_max_count;

    // Clearing restarts the peak from the count this edge produces.
    always_ff @(posedge fe_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_max_count <= '0;
        end else if (I_clear_errors || (w_count_nxt > r_max_count)) begin
            r_max_count <= w_count_nxt;
        end
    end

    assign O_max_count = r_max_count;
`else
    assign O_max_count = '0;
`endif

    always_comb begin
        w_status           = '0;
        w_status.full_thr  = r_full_thr;
        w_status.ovf       = r_ovf_sticky;
        w_status.full      = r_full;
        w_status.empty_thr = r_empty_thr;
        w_status.unf       = r_unf_sticky;
        w_status.empty     = r_empty;
    end

    assign O_data             = r_data;
    assign O_data_valid       = r_data_vld;
    assign O_count            = r_count;
    assign O_full             = r_full;
    assign O_empty            = r_empty;
    assign O_full_threshold   = r_full_thr;
    assign O_empty_threshold  = r_empty_thr;
    assign O_overflow_sticky  = r_ovf_sticky;
    assign O_underflow_sticky = r_unf_sticky;
    assign O_overflow_count   = r_ovf_cnt;
    assign O_error_flag       = r_ovf_sticky | r_unf_sticky;
    assign O_fifo_status      = w_status;

endmodule

// File: tb/tb_capture_fifo_sync.sv
// Directed bench for capture_fifo_sync at depth 16: ordering, full/empty, errors, flush, thresholds, watermark and async reset.
module tb_capture_fifo_sync;

    localparam int DW = 18;
    localparam int DEPTH = 16;
    localparam int EW = 8;
    localparam int AW = 4;

    logic          fe_clk;
    logic          reset_n;
    logic          I_wr;
    logic [DW-1:0] I_data;
    logic          I_rd;
    logic          I_flush;
    logic          I_clear_errors;
    logic [AW:0]   I_full_thresh;
    logic [AW:0]   I_empty_thresh;
    logic [DW-1:0] O_data;
    logic          O_data_valid;
    logic [AW:0]   O_count;
    logic [AW:0]   O_max_count;
    logic          O_full;
    logic          O_empty;
    logic          O_full_threshold;
    logic          O_empty_threshold;
    logic          O_overflow_sticky;
    logic          O_underflow_sticky;
    logic [EW-1:0] O_overflow_count;
    logic          O_error_flag;
    logic [5:0]    O_fifo_status;

    int n_checks = 0;
    int n_errors = 0;

    capture_fifo_sync #(
        .pDATA_WIDTH(DW),
        .pDEPTH(DEPTH),
        .pERR_CNT_WIDTH(EW)
    ) dut (
        .fe_clk(fe_clk),
        .reset_n(reset_n),
        .I_wr(I_wr),
        .I_data(I_data),
        .I_rd(I_rd),
        .I_flush(I_flush),
        .I_clear_errors(I_clear_errors),
        .I_full_thresh(I_full_thresh),
        .I_empty_thresh(I_empty_thresh),
        .O_data(O_data),
        .O_data_valid(O_data_valid),
        .O_count(O_count),
        .O_max_count(O_max_count),
        .O_full(O_full),
        .O_empty(O_empty),
        .O_full_threshold(O_full_threshold),
        .O_empty_threshold(O_empty_threshold),
        .O_overflow_sticky(O_overflow_sticky),
        .O_underflow_sticky(O_underflow_sticky),
        .O_overflow_count(O_overflow_count),
        .O_error_flag(O_error_flag),
        .O_fifo_status(O_fifo_status)
    );

    initial fe_clk = 1'b0;
    always #5 fe_clk = ~fe_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs set before the call are sampled on the next edge; outputs are read 1ns later.
    task automatic step();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"},  32'(O_count), 32'd0);
        check({tag, "_empty"},  32'(O_empty), 32'd1);
        check({tag, "_full"},   32'(O_full), 32'd0);
        check({tag, "_fthr"},   32'(O_full_threshold), 32'd0);
        check({tag, "_ethr"},   32'(O_empty_threshold), 32'd0);
        check({tag, "_data"},   32'(O_data), 32'd0);
        check({tag, "_valid"},  32'(O_data_valid), 32'd0);
        check({tag, "_ovfcnt"}, 32'(O_overflow_count), 32'd0);
        check({tag, "_errflg"}, 32'(O_error_flag), 32'd0);
        check({tag, "_max"},    32'(O_max_count), 32'd0);
        check({tag, "_status"}, 32'(O_fifo_status), 32'h01);
    endtask

    initial begin
        logic exp_f;
        logic exp_e;
        int   exp_max;

        reset_n        = 1'b0;
        I_wr           = 1'b0;
        I_data         = '0;
        I_rd           = 1'b0;
        I_flush        = 1'b0;
        I_clear_errors = 1'b0;
        I_full_thresh  = 5'd16;
        I_empty_thresh = 5'd0;
        repeat (3) step();
        check_reset_values("rst");
        reset_n = 1'b1;
        step();

        // Fill 0x00..0x0F, then drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            I_wr   = 1'b1;
            I_data = DW'(i);
            step();
            if (i == DEPTH - 2) check("full_at15", 32'(O_full), 32'd0);
        end
        I_wr = 1'b0;
        check("count_16", 32'(O_count), 32'd16);
        check("full_at16", 32'(O_full), 32'd1);
        check("status_full", 32'(O_fifo_status), 32'h28);
        check("valid_idle", 32'(O_data_valid), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            I_rd = 1'b1;
            step();
            check("rd_valid", 32'(O_data_valid), 32'd1);
            check("rd_data", 32'(O_data), 32'(i));
        end
        I_rd = 1'b0;
        step();
        check("valid_drop", 32'(O_data_valid), 32'd0);
        check("data_hold", 32'(O_data), 32'h0F);
        check("empty_end", 32'(O_empty), 32'd1);
        check("count_end", 32'(O_count), 32'd0);

        // Overflow while full: each blocked write has a coincident read, then a refill write.
        for (int i = 0; i < DEPTH; i++) begin
            I_wr   = 1'b1;
            I_data = DW'(32'h100 + i);
            step();
        end
        for (int k = 0; k < 3; k++) begin
            I_wr = 1'b1;
            I_rd = 1'b1;
            I_data = 18'h3FFFF;
            step();
            check("ovf_count_after_rd", 32'(O_count), 32'd15);
            check("ovf_rd_data", 32'(O_data), 32'(32'h100 + k));
            I_rd = 1'b0;
            I_data = DW'(32'h1F0 + k);
            if (k < 2) begin
                step();
                check("refill_count", 32'(O_count), 32'd16);
            end
        end
        I_wr = 1'b0;
        check("ovf_cnt3", 32'(O_overflow_count), 32'd3);
        check("ovf_sticky", 32'(O_overflow_sticky), 32'd1);
        check("err_flag", 32'(O_error_flag), 32'd1);
        I_clear_errors = 1'b1;
        step();
        I_clear_errors = 1'b0;
        check("clr_ovf_cnt", 32'(O_overflow_count), 32'd0);
        check("clr_ovf_sticky", 32'(O_overflow_sticky), 32'd0);
        check("clr_err_flag", 32'(O_error_flag), 32'd0);
        I_flush = 1'b1;
        step();
        I_flush = 1'b0;
        check("flush_count", 32'(O_count), 32'd0);
        check("flush_data_hold", 32'(O_data), 32'h102);

        // Underflow on empty.
        I_rd = 1'b1;
        step();
        I_rd = 1'b0;
        check("unf_sticky", 32'(O_underflow_sticky), 32'd1);
        check("unf_valid", 32'(O_data_valid), 32'd0);
        check("unf_data", 32'(O_data), 32'h102);
        check("unf_status", 32'(O_fifo_status), 32'h03);
        I_clear_errors = 1'b1;
        step();
        I_clear_errors = 1'b0;
        check("unf_cleared", 32'(O_underflow_sticky), 32'd0);

        // Flush with coincident read and write at count 5.
        for (int i = 0; i < 5; i++) begin
            I_wr   = 1'b1;
            I_data = DW'(32'h200 + i);
            step();
        end
        check("count_5", 32'(O_count), 32'd5);
        I_flush = 1'b1;
        I_rd    = 1'b1;
        step();
        I_flush = 1'b0;
        I_wr    = 1'b0;
        I_rd    = 1'b0;
        check("fl_count", 32'(O_count), 32'd0);
        check("fl_empty", 32'(O_empty), 32'd1);
        check("fl_errflag", 32'(O_error_flag), 32'd0);
        check("fl_valid", 32'(O_data_valid), 32'd0);
        check("fl_data", 32'(O_data), 32'h102);

        // Programmable thresholds 12 / 3.
        I_full_thresh  = 5'd12;
        I_empty_thresh = 5'd3;
        step();
        check("thr0_e", 32'(O_empty_threshold), 32'd0);
        check("thr0_f", 32'(O_full_threshold), 32'd0);
        for (int i = 1; i <= 13; i++) begin
            I_wr   = 1'b1;
            I_data = DW'(i);
            step();
            exp_f = (i >= 12);
            exp_e = (i <= 3);
            check("thr_full", 32'(O_full_threshold), 32'(exp_f));
            check("thr_empty", 32'(O_empty_threshold), 32'(exp_e));
        end
        I_wr = 1'b0;
        check("thr_status", 32'(O_fifo_status), 32'h20);

        // Watermark: restart peak at 0, fill to 10, drain to 2.
        I_flush = 1'b1;
        step();
        I_flush = 1'b0;
        I_clear_errors = 1'b1;
        step();
        I_clear_errors = 1'b0;
        for (int i = 0; i < 10; i++) begin
            I_wr   = 1'b1;
            I_data = DW'(32'h300 + i);
            step();
        end
        I_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            I_rd = 1'b1;
            step();
        end
        I_rd = 1'b0;
`ifdef CAPTURE_FIFO_WATERMARK_EN
        exp_max = 10;
`else
        exp_max = 0;
`endif
        check("wm_count", 32'(O_count), 32'd2);
        check("wm_data", 32'(O_data), 32'h307);
        check("wm_max", 32'(O_max_count), 32'(exp_max));

        // Asynchronous reset mid-fill, asserted away from the clock edge.
        for (int i = 0; i < 3; i++) begin
            I_wr   = 1'b1;
            I_data = DW'(32'h310 + i);
            step();
        end
        I_wr = 1'b0;
        I_rd = 1'b1;
        step();
        check("pre_rst_valid", 32'(O_data_valid), 32'd1);
        check("pre_rst_count", 32'(O_count), 32'd4);
        I_rd = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("arst");
        step();
        reset_n = 1'b1;
        I_wr    = 1'b1;
        I_data  = 18'h3AB;
        step();
        I_wr = 1'b0;
        check("post_rst_count", 32'(O_count), 32'd1);
        check("post_rst_empty", 32'(O_empty), 32'd0);
        I_rd = 1'b1;
        step();
        I_rd = 1'b0;
        check("post_rst_data", 32'(O_data), 32'h3AB);
        check("post_rst_valid", 32'(O_data_valid), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
